axis_pkt_arbiter: RTL and testbench

AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

---
 rtl/axis_pkt_arbiter.sv | 110 +++++++++++
 tb/tb_axis_pkt_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arbiter.sv
// rtl/axis_pkt_arbiter.sv - two-port packet round-robin arbiter feeding a sync FIFO write port
// Optional per-port packet counters: define AXIS_ARB_STATS_EN.
module axis_pkt_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_tvalid,
  output logic             s0_tready,
  input  logic [WIDTH-1:0] s0_tdata,
  input  logic             s0_tlast,
  input  logic             s1_tvalid,
  output logic             s1_tready,
  input  logic [WIDTH-1:0] s1_tdata,
  input  logic             s1_tlast,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_din,
  output logic             fifo_din_last,
  input  logic             fifo_full,
  output logic             busy,
`ifdef AXIS_ARB_STATS_EN
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
`endif
  output logic             grant_id
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t state, state_next;
  logic   rr_ptr;
  logic   last_acc;

  // rr_ptr names the last-served port; a tie goes to the other one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b1;
      grant_id <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next != IDLE)
        grant_id <= (state_next == GRANT1);
      if (last_acc)
        rr_ptr <= (state == GRANT1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (s0_tvalid && s1_tvalid)
          state_next = rr_ptr ? GRANT0 : GRANT1;
        else if (s0_tvalid)
          state_next = GRANT0;
        else if (s1_tvalid)
          state_next = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (last_acc)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s0_tready     = 1'b0;
    s1_tready     = 1'b0;
    fifo_wr_en    = 1'b0;
    fifo_din      = '0;
    fifo_din_last = 1'b0;
    busy          = 1'b0;
    case (state)
      GRANT0: begin
        busy          = 1'b1;
        s0_tready     = !fifo_full;
        fifo_wr_en    = s0_tvalid && !fifo_full;
        fifo_din      = s0_tdata;
        fifo_din_last = s0_tlast;
      end
      GRANT1: begin
        busy          = 1'b1;
        s1_tready     = !fifo_full;
        fifo_wr_en    = s1_tvalid && !fifo_full;
        fifo_din      = s1_tdata;
        fifo_din_last = s1_tlast;
      end
      default: ;
    endcase
    last_acc = fifo_wr_en && fifo_din_last;
  end

`ifdef AXIS_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (last_acc) begin
      if (state == GRANT0)
        pkt_cnt0 <= pkt_cnt0 + 1'b1;
      else
        pkt_cnt1 <= pkt_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb/tb_axis_pkt_arbiter.sv - scoreboard bench for axis_pkt_arbiter
module tb_axis_pkt_arbiter;
  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic             s0_tready, s1_tready;
  logic [WIDTH-1:0] s0_tdata = '0, s1_tdata = '0;
  logic             s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic             fifo_wr_en;
  logic [WIDTH-1:0] fifo_din;
  logic             fifo_din_last;
  logic             fifo_full = 1'b0;
  logic             busy;
  logic             grant_id;
`ifdef AXIS_ARB_STATS_EN
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;
`endif

  axis_pkt_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata), .s1_tlast(s1_tlast),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_din_last(fifo_din_last),
    .fifo_full(fifo_full), .busy(busy),
`ifdef AXIS_ARB_STATS_EN
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
`endif
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int nwr = 0;
  logic [WIDTH:0] q0[$];
  logic [WIDTH:0] q1[$];
  logic [WIDTH:0] sb[$];
  int wcyc[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Source models: present the head of each queue, pop it once the handshake is seen.
  initial begin : src0
    logic acc;
    forever begin
      @(negedge clk);
      acc = s0_tvalid && s0_tready;
      @(posedge clk);
      #1;
      if (acc && q0.size() > 0) void'(q0.pop_front());
      s0_tvalid = (q0.size() > 0);
      if (q0.size() > 0) {s0_tlast, s0_tdata} = q0[0];
    end
  end

  initial begin : src1
    logic acc;
    forever begin
      @(negedge clk);
      acc = s1_tvalid && s1_tready;
      @(posedge clk);
      #1;
      if (acc && q1.size() > 0) void'(q1.pop_front());
      s1_tvalid = (q1.size() > 0);
      if (q1.size() > 0) {s1_tlast, s1_tdata} = q1[0];
    end
  end

  initial begin : monitor
    logic [WIDTH:0] exp;
    forever begin
      @(negedge clk);
      if (fifo_wr_en) begin
        nwr++;
        wcyc.push_back(cyc);
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL fifo_write: unexpected write last=%0b din=%02h, none expected", fifo_din_last, fifo_din);
        end else begin
          exp = sb.pop_front();
          if ({fifo_din_last, fifo_din} !== exp) begin
            miscompares++;
            $display("FAIL fifo_write: got last=%0b din=%02h, expected last=%0b din=%02h",
                     fifo_din_last, fifo_din, exp[WIDTH], exp[WIDTH-1:0]);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0 && q0.size() == 0 && q1.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_drain: timeout, %0d writes outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic wait_writes(input int target, input string name);
    bit done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (nwr >= target) begin
        done = 1;
        break;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_wait: write count %0d, required %0d", name, nwr, target);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({s0_tready, s1_tready, fifo_wr_en, busy, grant_id} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %05b, required 00000", {s0_tready, s1_tready, fifo_wr_en, busy, grant_id});
    end
`ifdef AXIS_ARB_STATS_EN
    vectors++;
    if (pkt_cnt0 !== '0 || pkt_cnt1 !== '0) begin
      miscompares++;
      $display("FAIL reset_counters: got %0d/%0d, required 0/0", pkt_cnt0, pkt_cnt1);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_port();
    int s1_rdy_seen = 0;
    bit done = 0;
    sb.push_back({1'b0, 8'h11});
    sb.push_back({1'b0, 8'h22});
    sb.push_back({1'b1, 8'h33});
    q0.push_back({1'b0, 8'h11});
    q0.push_back({1'b0, 8'h22});
    q0.push_back({1'b1, 8'h33});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (s1_tready) s1_rdy_seen++;
      if (sb.size() == 0 && q0.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL single_drain: timeout, %0d writes outstanding, required 0", sb.size());
    end
    vectors++;
    if (s1_rdy_seen != 0) begin
      miscompares++;
      $display("FAIL single_s1_tready: high for %0d cycles, required 0", s1_rdy_seen);
    end
    vectors++;
    if (grant_id !== 1'b0) begin
      miscompares++;
      $display("FAIL single_grant_hold: grant_id=%0b, required 0", grant_id);
    end
  endtask

  task automatic test_round_robin();
    int b;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q0.push_back({i == 1, 8'hA0 + 8'(i)});
      q1.push_back({i == 1, 8'hB0 + 8'(i)});
    end
    for (int i = 0; i < 2; i++) q0.push_back({i == 1, 8'hC0 + 8'(i)});
    for (int i = 0; i < 2; i++) sb.push_back({i == 1, 8'hA0 + 8'(i)});
    for (int i = 0; i < 2; i++) sb.push_back({i == 1, 8'hB0 + 8'(i)});
    for (int i = 0; i < 2; i++) sb.push_back({i == 1, 8'hC0 + 8'(i)});
    b = wcyc.size();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_drain("rr");
    vectors++;
    if (wcyc.size() != b + 6) begin
      miscompares++;
      $display("FAIL rr_count: %0d writes, required 6", wcyc.size() - b);
    end else begin
      vectors++;
      if (wcyc[b+2] - wcyc[b+1] != 2 || wcyc[b+4] - wcyc[b+3] != 2) begin
        miscompares++;
        $display("FAIL rr_idle_gap: gaps %0d,%0d, required 2,2", wcyc[b+2] - wcyc[b+1], wcyc[b+4] - wcyc[b+3]);
      end
      vectors++;
      if (wcyc[b+1] - wcyc[b] != 1 || wcyc[b+3] - wcyc[b+2] != 1 || wcyc[b+5] - wcyc[b+4] != 1) begin
        miscompares++;
        $display("FAIL rr_beat_spacing: %0d,%0d,%0d, required 1,1,1",
                 wcyc[b+1] - wcyc[b], wcyc[b+3] - wcyc[b+2], wcyc[b+5] - wcyc[b+4]);
      end
    end
  endtask

  task automatic test_fifo_full();
    int base = nwr;
    for (int i = 0; i < 4; i++) begin
      q1.push_back({i == 3, 8'hD0 + 8'(i)});
      sb.push_back({i == 3, 8'hD0 + 8'(i)});
    end
    wait_writes(base + 2, "full");
    @(posedge clk);
    #1 fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({s1_tready, fifo_wr_en, grant_id, busy} !== 4'b0011) begin
        miscompares++;
        $display("FAIL full_stall_%0d: tready/wr_en/grant_id/busy=%04b, required 0011", i,
                 {s1_tready, fifo_wr_en, grant_id, busy});
      end
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    wait_drain("full");
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      q0.push_back({1'b1, 8'h40 + 8'(i)});
      q1.push_back({1'b1, 8'h80 + 8'(i)});
      sb.push_back({1'b1, 8'h40 + 8'(i)});
      sb.push_back({1'b1, 8'h80 + 8'(i)});
    end
    wait_drain("alt");
`ifdef AXIS_ARB_STATS_EN
    vectors++;
    if (pkt_cnt0 !== 16'd10 || pkt_cnt1 !== 16'd10) begin
      miscompares++;
      $display("FAIL alt_counters: got %0d/%0d, required 10/10", pkt_cnt0, pkt_cnt1);
    end
`endif
  endtask

  task automatic test_reset_mid_packet();
    int base = nwr;
    for (int i = 0; i < 5; i++) q0.push_back({i == 4, 8'hE0 + 8'(i)});
    sb.push_back({1'b0, 8'hE0});
    sb.push_back({1'b0, 8'hE1});
    wait_writes(base + 2, "rstmid");
    @(posedge clk);
    #1 rst = 1'b1;
    q0.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({s0_tready, s1_tready, fifo_wr_en, busy, grant_id} !== 5'b0) begin
        miscompares++;
        $display("FAIL rstmid_outputs_%0d: got %05b, required 00000", i,
                 {s0_tready, s1_tready, fifo_wr_en, busy, grant_id});
      end
    end
`ifdef AXIS_ARB_STATS_EN
    vectors++;
    if (pkt_cnt0 !== '0 || pkt_cnt1 !== '0) begin
      miscompares++;
      $display("FAIL rstmid_counters: got %0d/%0d, required 0/0", pkt_cnt0, pkt_cnt1);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      q1.push_back({i == 1, 8'hF0 + 8'(i)});
      sb.push_back({i == 1, 8'hF0 + 8'(i)});
    end
    wait_drain("rstmid");
    vectors++;
    if (grant_id !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_regrant: grant_id=%0b, required 1", grant_id);
    end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_fifo_full();
    test_alternate();
    test_reset_mid_packet();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
